// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, memory FSM states and request bundle.
// Also holds the request decode used by the data memory.
package wb_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam int WB_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } wb_mem_state_t;

  typedef struct packed {
    logic [WB_DAT_W-1:0] dat;
    logic [WB_SEL_W-1:0] sel;
    logic                we;
  } wb_req_t;

  // lim is one past the last valid byte address, one bit wider
  // than the bus so a window ending at 4 GiB still compares right.
  function automatic logic wb_req_bad(
    input logic [WB_ADR_W-1:0] adr,
    input logic [WB_SEL_W-1:0] sel,
    input logic [WB_ADR_W-1:0] base,
    input logic [WB_ADR_W:0]   lim
  );
    return (adr[1:0] != 2'b00) ||
           (adr < base) ||
           ({1'b0, adr} >= lim) ||
           (sel == '0);
  endfunction

endpackage

// File: rtl/wb_data_mem_if.sv
// wb_data_mem_if: Wishbone classic bus between one master and the memory.
// Signals: cyc/stb/adr/dat/sel/we toward slave; dat/ack/err back.
interface wb_data_mem_if;
  import wb_pkg::*;

  logic                cyc_i;
  logic                stb_i;
  logic [WB_ADR_W-1:0] adr_i;
  logic [WB_DAT_W-1:0] dat_i;
  logic [WB_SEL_W-1:0] sel_i;
  logic                we_i;
  logic [WB_DAT_W-1:0] dat_o;
  logic                ack_o;
  logic                err_o;

  modport slave (
    input  cyc_i, stb_i, adr_i, dat_i, sel_i, we_i,
    output dat_o, ack_o, err_o
  );

  modport master (
    output cyc_i, stb_i, adr_i, dat_i, sel_i, we_i,
    input  dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_mem_array.sv
// wb_mem_array: single-port byte-enabled RAM, MEM_WORDS x 32, registered read.
// Ports: clk_i, rst_i, en_i, we_i, be_i, adr_i, wdat_i -> rdat_o.
module wb_mem_array
  import wb_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                we_i,
  input  logic [WB_SEL_W-1:0] be_i,
  input  logic [AW-1:0]       adr_i,
  input  logic [WB_DAT_W-1:0] wdat_i,
  output logic [WB_DAT_W-1:0] rdat_o
);

  logic [WB_DAT_W-1:0] mem_q [MEM_WORDS];

  // Array contents are never reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (be_i[b]) begin
          mem_q[adr_i][8*b +: 8] <= wdat_i[8*b +: 8];
        end
      end
    end
  end

  // Read register only moves on a read, so it holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdat_o <= '0;
    end else if (en_i && !we_i) begin
      rdat_o <= mem_q[adr_i];
    end
  end

endmodule

// File: rtl/wb_data_mem.sv
// wb_data_mem: Wishbone slave data memory with programmable wait states.
// Ports: clk_i, rst_i (sync, active high), bus (wb_data_mem_if.slave).
module wb_data_mem
  import wb_pkg::*;
#(
  parameter int                  MEM_WORDS   = 1024,
  parameter logic [WB_ADR_W-1:0] BASE_ADR    = 32'h0000_0000,
  parameter int                  WAIT_STATES = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_data_mem_if.slave bus
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int LW = WB_ADR_W + 1;
  localparam logic [LW-1:0] LIM =
    {1'b0, BASE_ADR} + LW'(4 * MEM_WORDS);

  wb_mem_state_t state_q;
  wb_mem_state_t state_d;

  logic [3:0]    cnt_q;
  logic [3:0]    cnt_d;
  logic          ack_q;
  logic          ack_d;
  logic          err_q;
  logic          err_d;
  logic          err_pend_q;
  logic          err_pend_d;
  logic          lat_en;
  logic          mem_en;
  logic          hit;
  logic          bad;
  wb_req_t       req_q;
  logic [AW-1:0] idx_q;
  logic [WB_DAT_W-1:0] rdat;

  assign hit = bus.cyc_i & bus.stb_i;
  assign bad = wb_req_bad(bus.adr_i, bus.sel_i, BASE_ADR, LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = bad ? HOLD : WAIT;
        end
      end
      WAIT: begin
        if (!hit) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Errors are flagged on the sampling edge and emitted one edge
  // later, so err_o lines up with where a zero-wait ack would sit.
  always_comb begin
    ack_d      = 1'b0;
    err_d      = err_pend_q;
    err_pend_d = 1'b0;
    cnt_d      = cnt_q;
    lat_en     = 1'b0;
    mem_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          lat_en = 1'b1;
          if (bad) begin
            err_pend_d = 1'b1;
          end else begin
            cnt_d = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!hit) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          ack_d  = 1'b1;
          mem_en = ~rst_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: ;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (lat_en) begin
      req_q.dat <= bus.dat_i;
      req_q.sel <= bus.sel_i;
      req_q.we  <= bus.we_i;
      idx_q     <= AW'((bus.adr_i - BASE_ADR) >> 2);
    end
  end

  wb_mem_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .en_i   (mem_en),
    .we_i   (req_q.we),
    .be_i   (req_q.sel),
    .adr_i  (idx_q),
    .wdat_i (req_q.dat),
    .rdat_o (rdat)
  );

  assign bus.dat_o = rdat;
  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;

endmodule

// File: tb/tb_wb_data_mem.sv
// tb_wb_data_mem: random and directed checks of wb_data_mem
// against a word-array reference model.
module tb_wb_data_mem;

  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WS    = 1;
  localparam int          ACK_LAT = WS + 2;
  localparam int          ERR_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_err = 1'b0;

  logic [31:0] mem_m [int];
  logic [31:0] rd_m;

  wb_data_mem_if bus ();

  wb_data_mem #(
    .MEM_WORDS   (WORDS),
    .BASE_ADR    (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if ((bus.ack_o && bus.err_o) ||
          (bus.ack_o && prev_ack) ||
          (bus.err_o && prev_err)) begin
        errors++;
        $display("FAIL pulse_rule: ack=%b err=%b prev_ack=%b prev_err=%b required single non-overlapping pulses",
                 bus.ack_o, bus.err_o, prev_ack, prev_err);
      end
    end
    prev_ack = bus.ack_o;
    prev_err = bus.err_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic ref_bad(logic [31:0] a, logic [3:0] s);
    longint unsigned la = a;
    longint unsigned lb = BASE;
    return (la % 4 != 0) || (la < lb) ||
           (la >= lb + 4 * WORDS) || (s == 4'd0);
  endfunction

  function automatic logic [31:0] ref_merge(
    logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic idle_bus();
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic xfer(
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  logic        w,
    output int          lat,
    output logic        ak,
    output logic        er,
    output logic [31:0] rd
  );
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.adr_i = a;
    bus.dat_i = d;
    bus.sel_i = s;
    bus.we_i  = w;
    lat = 0;
    ak  = 1'b0;
    er  = 1'b0;
    rd  = bus.dat_o;
    for (int i = 1; i <= 12 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o || bus.err_o) begin
        lat = i;
        ak  = bus.ack_o;
        er  = bus.err_o;
        rd  = bus.dat_o;
      end
    end
    idle_bus();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", bus.ack_o);
    end
    checks++;
    if (bus.err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: got %b want 0", bus.err_o);
    end
    checks++;
    if (bus.dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_dat: got %h want 0", bus.dat_o);
    end
    rd_m = 32'h0;
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    xfer(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, lat, ak, er, rd);
    mem_m[32'h10] = 32'hDEADBEEF;
    checks++;
    if (!(ak === 1'b1 && er === 1'b0 && lat == ACK_LAT && rd === rd_m)) begin
      errors++;
      $display("FAIL basic_write: ack=%b err=%b lat=%0d dat=%h want ack lat=%0d dat=%h",
               ak, er, lat, rd, ACK_LAT, rd_m);
    end
    xfer(32'h10, 32'h0, 4'h1, 1'b0, lat, ak, er, rd);
    rd_m = mem_m[32'h10];
    checks++;
    if (!(ak === 1'b1 && er === 1'b0 && lat == ACK_LAT)) begin
      errors++;
      $display("FAIL basic_read_ack: ack=%b err=%b lat=%0d want lat=%0d",
               ak, er, lat, ACK_LAT);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL basic_read_dat: got %h want DEADBEEF", rd);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    xfer(32'h10, 32'h11223344, 4'h5, 1'b1, lat, ak, er, rd);
    mem_m[32'h10] = ref_merge(mem_m[32'h10], 32'h11223344, 4'h5);
    xfer(32'h10, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = mem_m[32'h10];
    checks++;
    if (!(ak === 1'b1 && rd === rd_m && rd === 32'hDE22BE44)) begin
      errors++;
      $display("FAIL byte_lanes: ack=%b got %h want %h", ak, rd, rd_m);
    end
  endtask

  task automatic test_errors();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    logic [31:0] ea [3];
    logic [3:0]  es [3];
    logic        ew [3];
    ea[0] = 32'h12;   es[0] = 4'hF; ew[0] = 1'b0;
    ea[1] = 32'h1000; es[1] = 4'hF; ew[1] = 1'b0;
    ea[2] = 32'h10;   es[2] = 4'h0; ew[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xfer(ea[i], 32'h55AA55AA, es[i], ew[i], lat, ak, er, rd);
      checks++;
      if (!(er === 1'b1 && ak === 1'b0 && lat == ERR_LAT && rd === rd_m)) begin
        errors++;
        $display("FAIL err_case%0d: err=%b ack=%b lat=%0d dat=%h want err lat=%0d dat=%h",
                 i, er, ak, lat, rd, ERR_LAT, rd_m);
      end
    end
    xfer(32'h10, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = mem_m[32'h10];
    checks++;
    if (!(ak === 1'b1 && rd === rd_m)) begin
      errors++;
      $display("FAIL err_mem_unchanged: got %h want %h", rd, rd_m);
    end
  endtask

  task automatic test_abort();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    int acks;
    logic [31:0] old = $urandom;
    xfer(32'h20, old, 4'hF, 1'b1, lat, ak, er, rd);
    mem_m[32'h20] = old;
    for (int drop = 1; drop <= 2; drop++) begin
      acks = 0;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.adr_i = 32'h20;
      bus.dat_i = 32'hCAFEF00D;
      bus.sel_i = 4'hF;
      bus.we_i  = 1'b1;
      for (int i = 0; i < drop; i++) begin
        @(posedge clk); #1;
        if (bus.ack_o) acks++;
      end
      if (drop == 1) bus.cyc_i = 1'b0;
      else bus.stb_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (bus.ack_o) acks++;
      end
      idle_bus();
      checks++;
      if (acks != 0) begin
        errors++;
        $display("FAIL abort_ack%0d: got %0d acks want 0", drop, acks);
      end
    end
    xfer(32'h20, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = mem_m[32'h20];
    checks++;
    if (!(ak === 1'b1 && rd === old)) begin
      errors++;
      $display("FAIL abort_mem: got %h want %h", rd, old);
    end
  endtask

  task automatic test_hold();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    int acks = 0;
    int errs = 0;
    int seen = 0;
    logic [31:0] d1 = $urandom;
    logic [31:0] d2 = ~d1;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.adr_i = 32'h30;
    bus.dat_i = d1;
    bus.sel_i = 4'hF;
    bus.we_i  = 1'b1;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin acks++; seen = 1; end
      if (bus.err_o) errs++;
    end
    bus.dat_i = d2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) acks++;
      if (bus.err_o) errs++;
    end
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) acks++;
      if (bus.err_o) errs++;
    end
    mem_m[32'h30] = d1;
    checks++;
    if (acks != 1 || errs != 0) begin
      errors++;
      $display("FAIL hold_acks: acks=%0d errs=%0d want 1 and 0", acks, errs);
    end
    xfer(32'h30, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = mem_m[32'h30];
    checks++;
    if (!(ak === 1'b1 && rd === d1)) begin
      errors++;
      $display("FAIL hold_one_write: got %h want %h", rd, d1);
    end
  endtask

  task automatic test_reset_wait();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    logic [31:0] v40 = $urandom | 32'h1;
    logic [31:0] vtop = $urandom;
    xfer(32'h40, v40, 4'hF, 1'b1, lat, ak, er, rd);
    mem_m[32'h40] = v40;
    xfer(32'hFFC, vtop, 4'hF, 1'b1, lat, ak, er, rd);
    mem_m[32'hFFC] = vtop;
    xfer(32'h40, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = v40;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    bus.adr_i = 32'h40;
    bus.dat_i = ~v40;
    bus.sel_i = 4'hF;
    bus.we_i  = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.ack_o !== 1'b0 || bus.dat_o !== 32'h0) begin
        errors++;
        $display("FAIL rst_wait%0d: ack=%b dat=%h want 0 and 0",
                 i, bus.ack_o, bus.dat_o);
      end
    end
    idle_bus();
    rst = 1'b0;
    rd_m = 32'h0;
    @(posedge clk); #1;
    xfer(32'hFFC, 32'h0, 4'h2, 1'b0, lat, ak, er, rd);
    rd_m = vtop;
    checks++;
    if (!(ak === 1'b1 && er === 1'b0 && lat == ACK_LAT && rd === vtop)) begin
      errors++;
      $display("FAIL top_read: ack=%b lat=%0d got %h want %h",
               ak, lat, rd, vtop);
    end
    xfer(32'h40, 32'h0, 4'hF, 1'b0, lat, ak, er, rd);
    rd_m = v40;
    checks++;
    if (!(ak === 1'b1 && rd === v40)) begin
      errors++;
      $display("FAIL rst_no_write: got %h want %h", rd, v40);
    end
  endtask

  task automatic test_random();
    int lat;
    logic ak, er;
    logic [31:0] rd;
    logic [31:0] set [16];
    set[0] = 32'h0;
    set[1] = 32'hFFC;
    for (int i = 2; i < 16; i++) set[i] = 32'($urandom_range(0, WORDS - 1)) * 4;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] v = $urandom;
      xfer(set[i], v, 4'hF, 1'b1, lat, ak, er, rd);
      mem_m[set[i]] = v;
      checks++;
      if (ak !== 1'b1) begin
        errors++;
        $display("FAIL rnd_preload%0d: ack=%b want 1", i, ak);
      end
    end
    for (int n = 0; n < 150; n++) begin
      int r = $urandom_range(0, 7);
      logic [31:0] a = set[$urandom_range(0, 15)];
      logic [31:0] d = $urandom;
      logic [3:0]  s = 4'($urandom_range(0, 15));
      logic        w = 1'($urandom_range(0, 1));
      logic        eb;
      if (r == 0) a = a | 32'($urandom_range(1, 3));
      if (r == 1) a = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
      eb = ref_bad(a, s);
      xfer(a, d, s, w, lat, ak, er, rd);
      if (!eb) begin
        if (w) mem_m[a] = ref_merge(mem_m[a], d, s);
        else rd_m = mem_m[a];
      end
      checks++;
      if (ak !== !eb || er !== eb ||
          lat != (eb ? ERR_LAT : ACK_LAT) || rd !== rd_m) begin
        errors++;
        $display("FAIL rnd%0d: a=%h s=%h w=%b ack=%b err=%b lat=%0d dat=%h want bad=%b dat=%h",
                 n, a, s, w, ak, er, lat, rd, eb, rd_m);
      end
    end
  endtask

  task automatic test_back_to_back();
    int t [4];
    int got = 0;
    for (int n = 0; n < 4; n++) begin
      int seen = 0;
      bus.cyc_i = 1'b1;
      bus.stb_i = 1'b1;
      bus.adr_i = 32'h10;
      bus.sel_i = 4'hF;
      bus.we_i  = 1'b0;
      for (int i = 0; i < 12 && seen == 0; i++) begin
        @(posedge clk); #1;
        if (bus.ack_o) begin
          seen = 1;
          t[n] = cyc_cnt;
          got++;
        end
      end
      idle_bus();
      @(posedge clk); #1;
    end
    rd_m = mem_m[32'h10];
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d acks want 4", got);
    end
    for (int n = 1; n < 4; n++) begin
      checks++;
      if (t[n] - t[n-1] < WS + 3) begin
        errors++;
        $display("FAIL b2b_gap%0d: got %0d cycles want >= %0d",
                 n, t[n] - t[n-1], WS + 3);
      end
    end
    checks++;
    if (bus.dat_o !== rd_m) begin
      errors++;
      $display("FAIL b2b_dat: got %h want %h", bus.dat_o, rd_m);
    end
  endtask

  initial begin
    idle_bus();
    bus.adr_i = '0;
    bus.dat_i = '0;
    bus.sel_i = '0;
    test_reset();
    test_basic();
    test_byte_lanes();
    test_errors();
    test_abort();
    test_hold();
    test_reset_wait();
    test_random();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_data_mem.md
WB_DATA_MEM -- requirements
Module: wb_data_mem

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words stored.
REQ-002 The block SHALL have parameter BASE_ADR, default 32'h0000_0000, byte address of word 0.
REQ-003 The block SHALL have parameter WAIT_STATES, default 1, extra cycles inserted before ack (0..15).
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; rst_i  in  1  synchronous active-high reset.
REQ-005 The block SHALL have these ports: cyc_i  in  1  bus cycle valid.
REQ-006 stb_i  in  1  strobe, request valid.
REQ-007 adr_i  in  32  byte address.
REQ-008 dat_i  in  32  write data.
REQ-009 sel_i  in  4  byte-lane select, bit n selects dat[8n+7:8n].
REQ-010 we_i  in  1  1 = write, 0 = read.
REQ-011 dat_o  out  32  registered read data.
REQ-012 ack_o  out  1  registered acknowledge, one cycle.
REQ-013 err_o  out  1  registered error, one cycle.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, HOLD; ack_o and err_o SHALL be registered pulses, not states.
REQ-015 In IDLE, when cyc_i&stb_i are sampled at edge k, the block SHALL latch adr/dat/sel/we and decode the request.
REQ-016 A request SHALL be in error if adr_i[1:0]!=0, or adr_i<BASE_ADR, or adr_i>=BASE_ADR+4*MEM_WORDS, or sel_i==0.
REQ-017 An error request SHALL assert err_o for exactly the cycle after edge k+1, with no memory change and dat_o unchanged, and the FSM SHALL go to HOLD.
REQ-018 A valid request SHALL load a wait counter with WAIT_STATES and enter WAIT; at edge k+1+WAIT_STATES the block SHALL perform the access and assert ack_o for one cycle, then enter HOLD.
REQ-019 A write SHALL update only the byte lanes whose sel bit is 1; other lanes SHALL keep their prior contents.
REQ-020 A read SHALL load dat_o with the full addressed word regardless of sel, on the same edge that ack_o rises.
REQ-021 dat_o SHALL hold its last value at all other times, including after writes and errors.
REQ-022 If cyc_i or stb_i is low at any edge while in WAIT, the block SHALL abort: no write, no ack, return to IDLE.
REQ-023 In HOLD, the block SHALL return to IDLE at the first edge where stb_i==0 or cyc_i==0, so that a strobe held after ack is never re-served.
REQ-024 ack_o and err_o SHALL never be high in the same cycle, and neither SHALL be high for two consecutive cycles.
REQ-025 The word index SHALL be (adr_i-BASE_ADR)>>2, truncated to clog2(MEM_WORDS) bits.
REQ-026 The request at the top boundary (BASE_ADR+4*MEM_WORDS-4) SHALL be served normally.
REQ-027 Throughput SHALL be at most one transfer per WAIT_STATES+3 cycles.

Reset
REQ-028 On reset, state SHALL be IDLE, the wait counter 0, ack_o=0, err_o=0, and dat_o=32'h0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset asserted in WAIT SHALL cancel the pending access, with no write and no ack.

Structure
REQ-031 Package wb_pkg SHALL hold WB_ADR_W=32, WB_DAT_W=32, WB_SEL_W=4, and the wb_mem_state_t enum {IDLE, WAIT, HOLD}.
REQ-032 Sub-module wb_mem_array SHALL implement a single-port, byte-enabled synchronous RAM (MEM_WORDS x 32) with registered read; the FSM SHALL live in wb_data_mem.

Verification
REQ-033 Scenario: WAIT_STATES=1; write adr=0x10, dat=0xDEADBEEF, sel=0xF, then read adr=0x10 -> ack_o 2 cycles after request sample; read dat_o=0xDEADBEEF.
REQ-034 Scenario: pre-load word 0x10=0xDEADBEEF; write dat=0x11223344, sel=0x5 -> readback 0xDE22BE44.
REQ-035 Scenario: read adr=0x12 (misaligned), then adr=0x1000 (MEM_WORDS=1024), then sel=0 -> err_o one cycle each, ack_o never, memory and dat_o unchanged.
REQ-036 Scenario: drop cyc_i during WAIT on a write of 0xCAFEF00D to 0x20 -> no ack; readback of 0x20 returns its old value.
REQ-037 Scenario: hold stb_i high 3 cycles after ack -> exactly one ack, one write.
REQ-038 Scenario: assert rst_i in WAIT -> ack_o=0, dat_o=0, state IDLE; a following read of 0xFFC (top word) -> normal ack.
